multicycle_ctrl: RTL

//  Multi-cycle sequencer for the RV32 datapath. Walks IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP and drives the datapath

---
 rtl/multicycle_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for an RV32 datapath. Steps through
//   IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP and drives the datapath strobes. One
//   memory port is shared between instruction fetch and load/store. The port
//   uses a ready handshake. A wait timeout sends the block to TRAP.
//
// Optional feature macro: PERF_CNT_EN
//   defined   -> 32-bit cycle and retired-instruction counters
//   undefined -> no counter registers; o_cycle_cnt and o_instret_cnt read 0
//
// Parameters
//   MEM_WAIT_MAX  max consecutive mem_ready=0 cycles in FETCH/MEM (>=1)
//
// Ports
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   i_run             start/continue, sampled in IDLE and at retire
//   i_op_code[6:0]    opcode from IR, valid in DECODE
//   i_mem_ready       memory completes the current access this cycle
//   o_pc_write        PC <= PC+4 (FETCH with mem_ready)
//   o_ir_write        IR <= rdata (same cycle as o_pc_write)
//   o_branch          branch evaluate (EXEC, B-type)
//   o_mem_read        read request (FETCH, MEM of loads)
//   o_mem_write       write request (MEM of stores)
//   o_mem_to_reg      writeback selects memory data (WB of loads)
//   o_alu_op[1:0]     00 add, 01 branch compare, 10 funct-decoded
//   o_alu_src         1 = immediate operand
//   o_reg_write_en    register file write (WB)
//   o_trap            high in TRAP (sticky until reset)
//   o_trap_cause[1:0] 00 none, 01 illegal, 10 fetch timeout, 11 data timeout
//   o_state[2:0]      IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6
//   o_cycle_cnt       active-cycle counter
//   o_instret_cnt     retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic [6:0]  i_op_code,
  input  logic        i_mem_ready,
  output logic        o_pc_write,
  output logic        o_ir_write,
  output logic        o_branch,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_mem_to_reg,
  output logic [1:0]  o_alu_op,
  output logic        o_alu_src,
  output logic        o_reg_write_en,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause,
  output logic [2:0]  o_state,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_instret_cnt
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OC_NONE  = 3'd0,
    OC_R     = 3'd1,
    OC_I     = 3'd2,
    OC_LOAD  = 3'd3,
    OC_STORE = 3'd4,
    OC_B     = 3'd5
  } op_class_t;

  // Map an opcode onto the instruction classes this sequencer supports.
  function automatic op_class_t decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: return OC_R;
      7'b0010011: return OC_I;
      7'b0000011: return OC_LOAD;
      7'b0100011: return OC_STORE;
      7'b1100011: return OC_B;
      default:    return OC_NONE;
    endcase
  endfunction

  state_t            r_state;
  op_class_t         r_op_class;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [1:0]        r_trap_cause;

  state_t    w_next_state;
  state_t    w_boundary_state;
  op_class_t w_dec_class;
  logic      w_retire;
  logic      w_wait_expired;
  logic      w_wait_clear;
  logic      w_wait_inc;
  logic [1:0] w_trap_cause_next;

  // Next-state decode, retire detection and trap cause selection.
  always_comb begin
    w_next_state      = r_state;
    w_retire          = 1'b0;
    w_trap_cause_next = r_trap_cause;
    w_dec_class       = decode_class(i_op_code);
    w_boundary_state  = i_run ? ST_FETCH : ST_IDLE;
    // ready in the expiry cycle wins over the timeout
    w_wait_expired    = (r_wait_cnt == WAIT_LIMIT) && !i_mem_ready;
    case (r_state)
      ST_IDLE: begin
        if (i_run) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (i_mem_ready) begin
          w_next_state = ST_DECODE;
        end else if (w_wait_expired) begin
          w_next_state      = ST_TRAP;
          w_trap_cause_next = 2'b10;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (w_dec_class == OC_NONE) begin
          w_next_state      = ST_TRAP;
          w_trap_cause_next = 2'b01;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (r_op_class)
          OC_R, OC_I:        w_next_state = ST_WB;
          OC_LOAD, OC_STORE: w_next_state = ST_MEM;
          OC_B: begin
            w_retire     = 1'b1;
            w_next_state = w_boundary_state;
          end
          default: begin
            w_next_state      = ST_TRAP;
            w_trap_cause_next = 2'b01;
          end
        endcase
      end
      ST_MEM: begin
        if (i_mem_ready) begin
          if (r_op_class == OC_LOAD) begin
            w_next_state = ST_WB;
          end else begin
            w_retire     = 1'b1;
            w_next_state = w_boundary_state;
          end
        end else if (w_wait_expired) begin
          w_next_state      = ST_TRAP;
          w_trap_cause_next = 2'b11;
        end else begin
          w_next_state = ST_MEM;
        end
      end
      ST_WB: begin
        w_retire     = 1'b1;
        w_next_state = w_boundary_state;
      end
      ST_TRAP: w_next_state = ST_TRAP;
      default: w_next_state = ST_IDLE;
    endcase
    // the counter restarts whenever a new memory access begins
    w_wait_clear = (w_next_state != r_state) &&
                   ((w_next_state == ST_FETCH) || (w_next_state == ST_MEM));
    w_wait_inc   = ((r_state == ST_FETCH) || (r_state == ST_MEM)) &&
                   !i_mem_ready && !w_wait_expired;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Op class latched once in DECODE, used by EXEC/MEM/WB.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op_class <= OC_NONE;
    end else if (r_state == ST_DECODE) begin
      r_op_class <= w_dec_class;
    end else begin
      r_op_class <= r_op_class;
    end
  end

  // Trap cause register; only written on the transition into TRAP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_trap_cause <= 2'b00;
    end else begin
      r_trap_cause <= w_trap_cause_next;
    end
  end

  // Memory wait counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (w_wait_clear) begin
      r_wait_cnt <= '0;
    end else if (w_wait_inc) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Datapath strobes decoded from state and latched op class.
  always_comb begin
    o_pc_write     = 1'b0;
    o_ir_write     = 1'b0;
    o_branch       = 1'b0;
    o_mem_read     = 1'b0;
    o_mem_write    = 1'b0;
    o_mem_to_reg   = 1'b0;
    o_alu_op       = 2'b00;
    o_alu_src      = 1'b0;
    o_reg_write_en = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_mem_read = 1'b1;
        o_pc_write = i_mem_ready;
        o_ir_write = i_mem_ready;
      end
      ST_EXEC: begin
        case (r_op_class)
          OC_R:                    o_alu_op = 2'b10;
          OC_I, OC_LOAD, OC_STORE: o_alu_src = 1'b1;
          OC_B: begin
            o_alu_op = 2'b01;
            o_branch = 1'b1;
          end
          default:                 o_alu_op = 2'b00;
        endcase
      end
      ST_MEM: begin
        if (r_op_class == OC_LOAD) begin
          o_mem_read = 1'b1;
        end else begin
          o_mem_write = (r_op_class == OC_STORE);
        end
      end
      ST_WB: begin
        o_reg_write_en = 1'b1;
        o_mem_to_reg   = (r_op_class == OC_LOAD);
      end
      default: o_alu_op = 2'b00;
    endcase
  end

  assign o_state      = r_state;
  assign o_trap       = (r_state == ST_TRAP);
  assign o_trap_cause = r_trap_cause;

`ifdef PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  // Performance counters; both hold in IDLE and TRAP and wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      if ((r_state != ST_IDLE) && (r_state != ST_TRAP)) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end else begin
        r_cycle_cnt <= r_cycle_cnt;
      end
      if (w_retire) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end else begin
        r_instret_cnt <= r_instret_cnt;
      end
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign o_cycle_cnt     = 32'd0;
  assign o_instret_cnt   = 32'd0;
`endif

endmodule
